// File: rtl/ps2_key_decoder_if.sv
// Pin- and command-side signals of the PS/2 key decoder.
// The decoder uses the slave modport; whatever drives the PS/2 pins and
// consumes the commands (board wrapper, testbench) uses the master modport.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [1:0] keyboard_signal;
    logic       key_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keyboard_signal,
        input  key_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keyboard_signal,
        output key_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and Set-2 scan-code decoder for the Tetris control path.
// Raw pins are synchronized, ps2_clk is debounced, 11-bit frames are checked,
// and the arrow/enter keys become a 2-bit command with a one-cycle strobe.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   ST_IDLE   | waiting for a start bit (data 0 on a bit event)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the odd-parity bit
//   ST_STOP   | checking stop bit and parity, handing byte onward
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_key_decoder_if.slave      bus
);

    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FILT_RELOAD = FCNT_W'(FILTER_LEN - 1);
    localparam logic [TCNT_W-1:0] TO_RELOAD   = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t              state;
    state_t              state_n;

    logic                clk_meta;
    logic                clk_sync;
    logic                data_meta;
    logic                data_sync;

    logic                filt_clk;
    logic [FCNT_W-1:0]   filt_cnt;
    logic                bit_event;

    logic [TCNT_W-1:0]   to_cnt;
    logic                timeout;

    logic [2:0]          bit_cnt;
    logic [7:0]          shift_reg;
    logic                parity_bit;

    logic                byte_done;
    logic                frame_bad;

    logic                ext;
    logic                brk;
    logic                cmd_hit;
    logic [1:0]          cmd_val;

    logic [1:0]          keyboard_signal_q;
    logic                key_valid_q;
    logic                frame_err_q;

    // Two-flop synchronizers on both pins; reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= bus.ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= bus.ps2_data;
            data_sync <= data_meta;
        end
    end

    // Stability filter: the filtered clock follows the synchronized clock only
    // after FILTER_LEN consecutive samples disagree with the current level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= FILT_RELOAD;
        end else if (clk_sync == filt_clk) begin
            filt_cnt <= FILT_RELOAD;
        end else if (filt_cnt == '0) begin
            filt_clk <= clk_sync;
            filt_cnt <= FILT_RELOAD;
        end else begin
            filt_cnt <= filt_cnt - FCNT_W'(1);
        end
    end

    // A bit event is the cycle in which the filtered clock is about to fall,
    // so data_sync is sampled in the same cycle the edge is accepted.
    assign bit_event = filt_clk & ~clk_sync & (filt_cnt == '0);

    // Inactivity down-counter; held at reload while idle or on every bit event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= TO_RELOAD;
        end else if ((state == ST_IDLE) || bit_event) begin
            to_cnt <= TO_RELOAD;
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TCNT_W'(1);
        end
    end

    assign timeout = (state != ST_IDLE) && !bit_event && (to_cnt == '0);

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Frame FSM next state plus the good-byte / bad-frame decisions.
    always_comb begin
        state_n   = state;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bit_event && !data_sync) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_event && (bit_cnt == 3'd7)) begin
                    state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (bit_event) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_event) begin
                    state_n = ST_IDLE;
                    if (data_sync && (^{shift_reg, parity_bit})) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (timeout) begin
            state_n   = ST_IDLE;
            frame_bad = 1'b1;
        end
    end

    // Bit counter, shift register and parity capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
        end else if (bit_event) begin
            case (state)
                ST_IDLE: begin
                    if (!data_sync) begin
                        bit_cnt <= 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_reg <= {data_sync, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                ST_PARITY: begin
                    parity_bit <= data_sync;
                end
                default: begin
                end
            endcase
        end
    end

    // Scan-code lookup for the byte just completed; arrows need the E0 prefix,
    // enter is accepted with or without it.
    always_comb begin
        cmd_hit = 1'b0;
        cmd_val = 2'b00;
        case (shift_reg)
            8'h75: begin
                cmd_hit = ext;
                cmd_val = 2'b00;
            end
            8'h6B: begin
                cmd_hit = ext;
                cmd_val = 2'b01;
            end
            8'h74: begin
                cmd_hit = ext;
                cmd_val = 2'b10;
            end
            8'h5A: begin
                cmd_hit = 1'b1;
                cmd_val = 2'b11;
            end
            default: begin
                cmd_hit = 1'b0;
                cmd_val = 2'b00;
            end
        endcase
        if (brk) begin
            cmd_hit = 1'b0;
        end
    end

    // Prefix flags and registered command/strobe outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext               <= 1'b0;
            brk               <= 1'b0;
            keyboard_signal_q <= 2'b00;
            key_valid_q       <= 1'b0;
            frame_err_q       <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (frame_bad) begin
                frame_err_q <= 1'b1;
                ext         <= 1'b0;
                brk         <= 1'b0;
            end else if (byte_done) begin
                if (shift_reg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (cmd_hit) begin
                        key_valid_q       <= 1'b1;
                        keyboard_signal_q <= cmd_val;
                    end
                end
            end
        end
    end

    assign bus.keyboard_signal = keyboard_signal_q;
    assign bus.key_valid       = key_valid_q;
    assign bus.frame_err       = frame_err_q;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives raw PS/2 keyboard frames, validates them and translates Set-2 scan codes into the 2-bit `keyboard_signal` command consumed by the Tetris game-control stage. A one-cycle `key_valid` strobe accompanies each command. The block sits directly between the board's PS/2 connector pins and game control, in the same `clk` domain as game control.

## Interface
- `FILTER_LEN`, 8: number of consecutive `clk` cycles a synchronized `ps2_clk` level must be stable to be accepted.
- `TIMEOUT_CYCLES`, 100000: `clk` cycles without an accepted `ps2_clk` falling edge before an in-progress frame is aborted (1 ms at 100 MHz).
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous to `clk`.
- `keyboard_signal` output 2: last decoded command; 00 up, 01 left, 10 right, 11 enter.
- `key_valid` output 1: one-cycle pulse marking a new command on `keyboard_signal`.
- `frame_err` output 1: one-cycle pulse on parity error, bad stop bit or timeout.

## Operation
- Input conditioning:
  - Each PS/2 line passes through a 2-FF synchronizer.
  - Synchronized `ps2_clk` feeds a stability filter: the filtered level changes only after `FILTER_LEN` identical consecutive samples.
  - A falling edge of the filtered clock is a "bit event". `ps2_data` (synchronized) is sampled in that cycle.
- Frame FSM, 11 bits per frame:
  - IDLE: on a bit event with data 0 (start bit), go to DATA and clear the bit counter. A bit event with data 1 is ignored.
  - DATA: 8 bit events, LSB first, shifted into the byte register; a 3-bit counter wraps to 0 after bit 7, then go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: the frame is good if the stop bit is 1 and the 9 data+parity bits have odd parity. Good frame: hand the byte to the decoder. Otherwise pulse `frame_err`. Either way return to IDLE.
- Timeout: a counter runs whenever the state is not IDLE and clears on each bit event. On reaching `TIMEOUT_CYCLES`, pulse `frame_err`, return to IDLE, and clear the prefix flags.
- Scan-code decoder, on each good byte:
  - E0: set `ext`.
  - F0: set `brk`.
  - Any other byte is looked up, and `ext` and `brk` are cleared in the same cycle.
  - The lookup emits a command only if `brk` = 0 and the byte is mapped:
    - E0 75 → 00
    - E0 6B → 01
    - E0 74 → 10
    - 5A or E0 5A → 11
  - Unmapped codes, non-extended 75/6B/74, and all break sequences produce no output.
  - Typematic repeats of a held key are make codes and each produces a pulse.
- `frame_err` clears `ext` and `brk`.

## Timing
- Reset values: `keyboard_signal` = 00, `key_valid` = 0, `frame_err` = 0, FSM = IDLE, `ext` = `brk` = 0, filter and synchronizers = 1 (idle bus level).
- Latency: `key_valid` and the new `keyboard_signal` are registered and appear the cycle after the stop-bit bit event. `frame_err` has the same latency.
- `keyboard_signal` holds its value between pulses and changes only together with `key_valid`.
- `key_valid` and `frame_err` are never high in the same cycle. Each is high for exactly one cycle per event.
- The minimum pin-to-strobe delay is 2 synchronizer cycles + `FILTER_LEN` cycles + 1 after the physical 11th falling edge.
- A reset asserted mid-frame discards the partial frame immediately. After release, decoding restarts with the next start bit.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no bit event.

## Test plan
- Reset, then send frames E0, 75 → one `key_valid` pulse with `keyboard_signal` = 00. Then send E0, F0, 75 → no pulse, `keyboard_signal` stays 00.
- Send 5A, then E0 6B, then E0 74 → three pulses with values 11, 01, 10 in order. Send unmapped 1C, and non-extended 75 → no pulse.
- Send a 5A frame with the parity bit inverted → `frame_err` pulse, no `key_valid`. Next a correct 5A → `key_valid` with 11.
- Send a frame with stop bit 0 → `frame_err`. Send E0 then a corrupted byte then 74 → no pulse, because the error cleared `ext`.
- Send start plus 4 data bits, then hold `ps2_clk` high for `TIMEOUT_CYCLES` + 10 → exactly one `frame_err`. A following E0 75 still decodes to 00.
- Inject 3-cycle low glitches on `ps2_clk` during a frame (`FILTER_LEN` = 8) → frame still decodes correctly. Assert `rst` low mid-frame → outputs return to reset values at once, and the next full frame decodes.
